// File: rtl/video_pkg.sv
// Shared types and widths for the Sobel window path.
package video_pkg;

    localparam int PIXEL_W   = 24;
    localparam int WIN_ROW_W = 72;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: single-port RAM, registered read, read-before-write.
module sobel_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Each access returns the previous contents and replaces them with the new word.
    always_ff @(posedge clk) begin
        if (i_en) begin
            o_rd_data      <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_controller.sv
// 3x3 window sequencer: tracks frame position, keeps two previous lines and
// presents three packed window rows to the edge datapath.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset; pixels ignored until a start-of-frame pixel
// FILL  | rows 0-1 of a frame; windows not yet complete
// RUN   | row 2 onward; windows may be emitted
module sobel_window_controller
    import video_pkg::*;
#(
    parameter int LINE_W = 640,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [PIXEL_W-1:0]   in_Pixel,
    input  logic                 in_Valid,
    input  logic                 in_Sof,
    input  logic                 in_Eol,
    output logic [WIN_ROW_W-1:0] out_M0,
    output logic [WIN_ROW_W-1:0] out_M1,
    output logic [WIN_ROW_W-1:0] out_M2,
    output logic                 out_Valid,
    output logic                 status,
    output logic                 err
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_col;
    logic [1:0]          r_row;
    logic                r_err;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_col_cur;
    logic [1:0]          w_row_cur;
    logic                w_at_last;
    logic                w_line_end;
    logic                w_len_err;
    logic                w_run_cur;

    // Stage 1: pixel accepted, lb0 accessed on the same edge.
    logic                r_v1;
    logic [PIXEL_W-1:0]  r_pix1;
    logic [ADDR_W-1:0]   r_col1;
    logic                r_run1;
    logic                r_en1;
    // Stage 2: lb1 accessed, lb0 data held to line up with it.
    logic                r_v2;
    logic [PIXEL_W-1:0]  r_pix2;
    logic [ADDR_W-1:0]   r_col2;
    logic                r_run2;
    logic                r_en2;
    logic [PIXEL_W-1:0]  r_lb0_q2;

    logic [PIXEL_W-1:0]  w_lb0_q;
    logic [PIXEL_W-1:0]  w_lb1_q;

    logic [WIN_ROW_W-1:0] r_win0;
    logic [WIN_ROW_W-1:0] r_win1;
    logic [WIN_ROW_W-1:0] r_win2;
    logic                 r_out_valid;

    // A start-of-frame pixel always restarts at (0,0), whatever the counters say.
    assign w_accept   = in_Valid && ((r_state != IDLE) || in_Sof);
    assign w_col_cur  = in_Sof ? '0 : r_col;
    assign w_row_cur  = in_Sof ? 2'd0 : r_row;
    assign w_at_last  = (w_col_cur == LAST_COL);
    assign w_line_end = in_Eol || w_at_last;
    assign w_len_err  = (in_Eol != w_at_last);
    assign w_run_cur  = (r_state == RUN) && !in_Sof;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a start-of-frame pixel wins from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (in_Sof) begin
                w_state_nxt = FILL;
            end else if ((r_state == FILL) && w_line_end && (r_row == 2'd1)) begin
                w_state_nxt = RUN;
            end
        end
    end

    // Column/row counters and sticky line-length error; a bad line still ends the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= 2'd0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (w_line_end) begin
                r_col <= '0;
                r_row <= (w_row_cur == 2'd2) ? 2'd2 : (w_row_cur + 2'd1);
            end else begin
                r_col <= w_col_cur + ADDR_W'(1);
                r_row <= w_row_cur;
            end
            r_err <= in_Sof ? w_len_err : (r_err | w_len_err);
        end
    end

    sobel_line_buffer #(
        .DEPTH  (LINE_W),
        .ADDR_W (ADDR_W),
        .DATA_W (PIXEL_W)
    ) u_lb0 (
        .clk       (clk),
        .i_en      (w_accept),
        .i_addr    (w_col_cur),
        .i_wr_data (in_Pixel),
        .o_rd_data (w_lb0_q)
    );

    // lb1 runs one cycle behind lb0 so it can store the row that lb0 just gave up.
    sobel_line_buffer #(
        .DEPTH  (LINE_W),
        .ADDR_W (ADDR_W),
        .DATA_W (PIXEL_W)
    ) u_lb1 (
        .clk       (clk),
        .i_en      (r_v1),
        .i_addr    (r_col1),
        .i_wr_data (w_lb0_q),
        .o_rd_data (w_lb1_q)
    );

    // Delay pipeline carrying the pixel and its position alongside the RAM reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
        end
        if (w_accept) begin
            r_pix1 <= in_Pixel;
            r_col1 <= w_col_cur;
            r_run1 <= w_run_cur;
            r_en1  <= en;
        end
        if (r_v1) begin
            r_pix2   <= r_pix1;
            r_col2   <= r_col1;
            r_run2   <= r_run1;
            r_en2    <= r_en1;
            r_lb0_q2 <= w_lb0_q;
        end
    end

    // Window chains shift toward column c-2; border windows shift but never strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win0      <= '0;
            r_win1      <= '0;
            r_win2      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v2 && r_run2 && (r_col2 > ADDR_W'(1)) && r_en2 && en;
            if (r_v2) begin
                r_win0 <= {w_lb1_q,  r_win0[WIN_ROW_W-1:PIXEL_W]};
                r_win1 <= {r_lb0_q2, r_win1[WIN_ROW_W-1:PIXEL_W]};
                r_win2 <= {r_pix2,   r_win2[WIN_ROW_W-1:PIXEL_W]};
            end
        end
    end

    assign out_M0    = r_win0;
    assign out_M1    = r_win1;
    assign out_M2    = r_win2;
    assign out_Valid = r_out_valid;
    assign status    = (r_state != IDLE);
    assign err       = r_err;

endmodule
